// File: rtl/event_ripple_seq.sv
// Key-press ripple animator: sweeps a blue->green->red wavefront across NUM_LEDS RGB LEDs.
// Optional feature macro: EVENT_RIPPLE_REVERSE_EN (adds `dir` input for reverse ripple).
module event_ripple_seq #(
  parameter int NUM_LEDS = 4,
  parameter int TICK_DIV = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                button_inp,
  input  logic                mode_loop,
`ifdef EVENT_RIPPLE_REVERSE_EN
  input  logic                dir,
`endif
  output logic [NUM_LEDS-1:0] led_R,
  output logic [NUM_LEDS-1:0] led_G,
  output logic [NUM_LEDS-1:0] led_B,
  output logic                busy,
  output logic                done
);

  localparam int NUM_STAGES = NUM_LEDS + 2;
  localparam int STG_W      = $clog2(NUM_STAGES);
  localparam int CNT_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [STG_W-1:0] LAST_STAGE = STG_W'(NUM_STAGES - 1);
  localparam logic [CNT_W-1:0] LAST_TICK  = CNT_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, WAIT_REL} state_t;

  state_t           state_q, state_d;
  logic [STG_W-1:0] stage_q, stage_d;
  logic [CNT_W-1:0] tick_q, tick_d;
  logic             done_q, done_d;
  logic             dir_sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      stage_q <= '0;
      tick_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    tick_d  = tick_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (button_inp) begin
          state_d = RUN;
          stage_d = '0;
          tick_d  = '0;
        end
      end
      RUN: begin
        // Release always wins, even on the final-stage boundary.
        if (!button_inp) begin
          state_d = IDLE;
          stage_d = '0;
          tick_d  = '0;
        end else if (tick_q == LAST_TICK) begin
          tick_d = '0;
          if (stage_q != LAST_STAGE) begin
            stage_d = stage_q + STG_W'(1);
          end else begin
            done_d  = 1'b1;
            stage_d = '0;
            if (!mode_loop) state_d = WAIT_REL;
          end
        end else begin
          tick_d = tick_q + CNT_W'(1);
        end
      end
      WAIT_REL: begin
        if (!button_inp) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        stage_d = '0;
        tick_d  = '0;
      end
    endcase
  end

`ifdef EVENT_RIPPLE_REVERSE_EN
  logic dir_q, dir_d;

  // Direction is latched at press time and held for the whole press.
  always_comb begin
    dir_d = dir_q;
    if (state_q == IDLE && button_inp) dir_d = dir;
  end

  always_ff @(posedge clk) begin
    if (rst) dir_q <= 1'b0;
    else     dir_q <= dir_d;
  end

  assign dir_sel = dir_q;
`else
  assign dir_sel = 1'b0;
`endif

  int pos;
  int d;

  always_comb begin
    led_R = '0;
    led_G = '0;
    led_B = '0;
    pos   = 0;
    d     = 0;
    if (state_q == RUN) begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        pos = dir_sel ? (NUM_LEDS - 1 - i) : i;
        d   = int'(stage_q) - pos;
        if (d == 0) led_B[i] = 1'b1;
        if (d == 1) led_G[i] = 1'b1;
        if (d == 2) led_R[i] = 1'b1;
      end
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;

endmodule

// File: tb/tb_event_ripple_seq.sv
// Self-checking bench for event_ripple_seq (NUM_LEDS=4, TICK_DIV=2) against an
// elapsed-cycle reference model; reverse tests only when EVENT_RIPPLE_REVERSE_EN is defined.
module tb_event_ripple_seq;

  localparam int N     = 4;
  localparam int TDIV  = 2;
  localparam int TOTAL = (N + 2) * TDIV;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         button_inp = 1'b0;
  logic         mode_loop = 1'b0;
  logic         dir = 1'b0;
  logic [N-1:0] led_R, led_G, led_B;
  logic         busy, done;

  int checks = 0;
  int errors = 0;

  // Reference model: run phase tracked as cycles elapsed since press.
  int m_st   = 0;
  int m_e    = 0;
  bit m_done = 1'b0;
  bit m_dir  = 1'b0;

  event_ripple_seq #(.NUM_LEDS(N), .TICK_DIV(TDIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .button_inp (button_inp),
    .mode_loop  (mode_loop),
`ifdef EVENT_RIPPLE_REVERSE_EN
    .dir        (dir),
`endif
    .led_R      (led_R),
    .led_G      (led_G),
    .led_B      (led_B),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  function automatic logic [3*N+1:0] model_out();
    logic [N-1:0] r, g, b;
    int stage, p;
    r = '0; g = '0; b = '0;
    if (m_st == 1) begin
      stage = m_e / TDIV;
      for (int i = 0; i < N; i++) begin
        p = m_dir ? (N - 1 - i) : i;
        if (stage - p == 0) b[i] = 1'b1;
        if (stage - p == 1) g[i] = 1'b1;
        if (stage - p == 2) r[i] = 1'b1;
      end
    end
    return {r, g, b, (m_st == 1), m_done};
  endfunction

  // One clock edge: the model consumes the same inputs the DUT samples.
  task automatic step();
    @(posedge clk);
    m_done = 1'b0;
    if (rst) begin
      m_st = 0;
      m_e  = 0;
    end else if (m_st == 0) begin
      if (button_inp) begin
        m_st  = 1;
        m_e   = 0;
`ifdef EVENT_RIPPLE_REVERSE_EN
        m_dir = dir;
`endif
      end
    end else if (m_st == 1) begin
      if (!button_inp) m_st = 0;
      else if (m_e == TOTAL - 1) begin
        m_done = 1'b1;
        m_e    = 0;
        if (!mode_loop) m_st = 2;
      end else m_e++;
    end else begin
      if (!button_inp) m_st = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; button_inp = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if ({led_R, led_G, led_B, busy, done} !== 14'd0) begin
        errors++;
        $display("[TB] FAIL reset cyc%0d: got %b want 0", k, {led_R, led_G, led_B, busy, done});
      end
    end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if ({led_R, led_G, led_B, busy, done} !== model_out()) begin
        errors++;
        $display("[TB] FAIL idle cyc%0d: got %b want %b", k, {led_R, led_G, led_B, busy, done}, model_out());
      end
    end
  endtask

  task automatic test_one_shot();
    mode_loop = 1'b0; button_inp = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      step();
      checks++;
      if ({led_R, led_G, led_B, busy, done} !== model_out()) begin
        errors++;
        $display("[TB] FAIL oneshot k%0d: got %b want %b", k, {led_R, led_G, led_B, busy, done}, model_out());
      end
      if (k == 1) begin
        checks++;
        if ({led_R, led_G, led_B, busy} !== {4'b0000, 4'b0000, 4'b0001, 1'b1}) begin
          errors++;
          $display("[TB] FAIL stage0: got %b want 0000_0000_0001_1", {led_R, led_G, led_B, busy});
        end
      end
      if (k == 5) begin
        checks++;
        if ({led_R, led_G, led_B} !== {4'b0001, 4'b0010, 4'b0100}) begin
          errors++;
          $display("[TB] FAIL stage2: got %b want 0001_0010_0100", {led_R, led_G, led_B});
        end
      end
      if (k == 11) begin
        checks++;
        if ({led_R, led_G, led_B} !== {4'b1000, 4'b0000, 4'b0000}) begin
          errors++;
          $display("[TB] FAIL stage5: got %b want 1000_0000_0000", {led_R, led_G, led_B});
        end
      end
      if (k == 13) begin
        checks++;
        if ({led_R, led_G, led_B, busy, done} !== {12'd0, 1'b0, 1'b1}) begin
          errors++;
          $display("[TB] FAIL done_pulse: got %b want 0..01", {led_R, led_G, led_B, busy, done});
        end
      end
    end
    button_inp = 1'b0;
    step();
    button_inp = 1'b1;
    step();
    checks++;
    if ({led_B, busy} !== {4'b0001, 1'b1}) begin
      errors++;
      $display("[TB] FAIL repress: got %b want 0001_1", {led_B, busy});
    end
    button_inp = 1'b0;
    step();
  endtask

  task automatic test_abort();
    button_inp = 1'b1; mode_loop = 1'b0;
    for (int k = 0; k < 7; k++) step();
    button_inp = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      checks++;
      if ({led_R, led_G, led_B, busy, done} !== 14'd0) begin
        errors++;
        $display("[TB] FAIL abort k%0d: got %b want 0", k, {led_R, led_G, led_B, busy, done});
      end
    end
  endtask

  task automatic test_loop();
    int pulses = 0;
    button_inp = 1'b1; mode_loop = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (done) pulses++;
      checks++;
      if ({led_R, led_G, led_B, busy, done} !== model_out() || busy !== 1'b1) begin
        errors++;
        $display("[TB] FAIL loop k%0d: got %b want %b", k, {led_R, led_G, led_B, busy, done}, model_out());
      end
    end
    checks++;
    if (pulses !== 2) begin
      errors++;
      $display("[TB] FAIL loop_pulses: got %0d want 2", pulses);
    end
    button_inp = 1'b0; mode_loop = 1'b0;
    step();
  endtask

  task automatic test_release_at_boundary();
    button_inp = 1'b1; mode_loop = 1'b0;
    for (int k = 0; k < TOTAL; k++) step();
    button_inp = 1'b0;
    step();
    checks++;
    if ({led_R, led_G, led_B, busy, done} !== 14'd0) begin
      errors++;
      $display("[TB] FAIL release_boundary: got %b want 0", {led_R, led_G, led_B, busy, done});
    end
  endtask

  task automatic test_reset_mid();
    button_inp = 1'b1;
    for (int k = 0; k < 5; k++) step();
    rst = 1'b1;
    step();
    checks++;
    if ({led_R, led_G, led_B, busy, done} !== 14'd0) begin
      errors++;
      $display("[TB] FAIL reset_mid: got %b want 0", {led_R, led_G, led_B, busy, done});
    end
    rst = 1'b0;
    step();
    checks++;
    if ({led_R, led_G, led_B, busy} !== {8'd0, 4'b0001, 1'b1}) begin
      errors++;
      $display("[TB] FAIL restart: got %b want 0..0001_1", {led_R, led_G, led_B, busy});
    end
    button_inp = 1'b0;
    step();
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      button_inp = ($urandom_range(0, 15) != 0) ? ~button_inp ^ ($urandom_range(0, 9) != 0) : ~button_inp;
      mode_loop  = $urandom_range(0, 1);
      dir        = $urandom_range(0, 1);
      rst        = ($urandom_range(0, 49) == 0);
      step();
      checks++;
      if ({led_R, led_G, led_B, busy, done} !== model_out()) begin
        errors++;
        $display("[TB] FAIL random k%0d: got %b want %b", k, {led_R, led_G, led_B, busy, done}, model_out());
      end
    end
    rst = 1'b0; button_inp = 1'b0; dir = 1'b0;
    step();
  endtask

`ifdef EVENT_RIPPLE_REVERSE_EN
  task automatic test_reverse();
    dir = 1'b1; button_inp = 1'b1; mode_loop = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      step();
      dir = ~dir;
      checks++;
      if ({led_R, led_G, led_B, busy, done} !== model_out()) begin
        errors++;
        $display("[TB] FAIL reverse k%0d: got %b want %b", k, {led_R, led_G, led_B, busy, done}, model_out());
      end
      if (k == 1 && led_B !== 4'b1000) begin
        errors++;
        $display("[TB] FAIL rev_stage0: got %b want 1000", led_B);
      end
      if (k == 5 && {led_R, led_G, led_B} !== {4'b1000, 4'b0100, 4'b0010}) begin
        errors++;
        $display("[TB] FAIL rev_stage2: got %b want 1000_0100_0010", {led_R, led_G, led_B});
      end
    end
    button_inp = 1'b0; dir = 1'b0;
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_one_shot();
    test_abort();
    test_loop();
    test_release_at_boundary();
    test_reset_mid();
`ifdef EVENT_RIPPLE_REVERSE_EN
    test_reverse();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
